// File: rtl/ecc_apb_engine.sv
`default_nettype none
// ============================================================================
// Module  : ecc_apb_engine
// Purpose : APB-programmed Hamming SECDED encode/decode/channel engine, 8/16/32-bit codewords
// Revision: 1.0
// ============================================================================
module ecc_apb_engine #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STAGE1 = 2'd1, S_STAGE2 = 2'd2} state_t;

  localparam logic [2:0] c_addr_ctrl   = 3'd0;
  localparam logic [2:0] c_addr_data   = 3'd1;
  localparam logic [2:0] c_addr_width  = 3'd2;
  localparam logic [2:0] c_addr_noise  = 3'd3;
  localparam logic [2:0] c_addr_status = 3'd4;

  state_t               r_state;
  logic [1:0]           r_ctrl;
  logic [AMBA_WORD-1:0] r_data_in;
  logic [1:0]           r_cw_width;
  logic [AMBA_WORD-1:0] r_noise;
  logic                 r_dropped;
  logic [1:0]           r_mode;
  logic [31:0]          r_snap_data;
  logic [1:0]           r_snap_width;
  logic [31:0]          r_snap_noise;
  logic [31:0]          r_recv;
  logic [4:0]           r_syn;
  logic                 r_par;

  logic        w_wr, w_rd_status, w_ctrl_wr, w_busy, w_start;
  logic [2:0]  w_addr;
  int          w_w;
  logic [31:0] w_enc, w_recv, w_corr, w_ext, w_result;
  logic [4:0]  w_syn;
  logic [1:0]  w_err;
  logic        w_unused;

  function automatic logic f_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic int f_width(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8;
      2'b01:   return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] f_encode(input logic [31:0] d, input int w);
    logic [31:0] c;
    int          k;
    logic        p;
    c = '0;
    k = 0;
    for (int i = 1; i < 32; i++) begin
      if (i < w && !f_pow2(i)) begin
        c[i-1] = d[k];
        k      = k + 1;
      end
    end
    // Parity positions start at zero, so each group XOR only sees data bits.
    for (int b = 0; b < 5; b++) begin
      p = 1'b0;
      for (int i = 1; i < 32; i++)
        if (i < w && i[b]) p = p ^ c[i-1];
      if ((1 << b) < w) c[(1<<b)-1] = p;
    end
    p = 1'b0;
    for (int i = 0; i < 31; i++)
      if (i < w - 1) p = p ^ c[i];
    c[w-1] = p;
    return c;
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] r, input int w);
    logic [31:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int i = 1; i < 32; i++) begin
      if (i < w && !f_pow2(i)) begin
        d[k] = r[i-1];
        k    = k + 1;
      end
    end
    return d;
  endfunction

  assign w_addr      = PADDR[4:2];
  assign w_wr        = PSEL & PENABLE & PWRITE;
  assign w_rd_status = PSEL & PENABLE & ~PWRITE & (w_addr == c_addr_status);
  assign w_ctrl_wr   = w_wr & (w_addr == c_addr_ctrl);
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = w_ctrl_wr & ~w_busy;
  assign w_unused    = ^{PADDR[1:0], PADDR[AMBA_ADDR_WIDTH-1:5]};

  // Stage 1: build the received word and its syndrome / overall parity.
  always_comb begin
    logic [31:0] v_mask;
    w_w    = f_width(r_snap_width);
    v_mask = (w_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w_w) - 32'd1);
    w_enc  = f_encode(r_snap_data, w_w);
    case (r_mode)
      2'b01:   w_recv = r_snap_data & v_mask;
      2'b10:   w_recv = (w_enc ^ r_snap_noise) & v_mask;
      default: w_recv = w_enc;
    endcase
    w_syn = '0;
    for (int i = 1; i < 32; i++)
      if (i < w_w && w_recv[i-1]) w_syn = w_syn ^ i[4:0];
  end

  // Stage 2: correct a single error (syndrome 0 means the overall parity bit).
  always_comb begin
    w_corr = r_recv;
    for (int i = 1; i < 32; i++)
      if (i < w_w && i == int'(r_syn)) w_corr[i-1] = ~r_recv[i-1];
    w_ext = f_extract(w_corr, w_w);
    if (r_mode == 2'b01 || r_mode == 2'b10) begin
      if (r_par) begin
        w_err    = 2'b01;
        w_result = w_ext;
      end else if (r_syn != 5'd0) begin
        w_err    = 2'b10;
        w_result = '0;
      end else begin
        w_err    = 2'b00;
        w_result = w_ext;
      end
    end else begin
      w_err    = 2'b00;
      w_result = r_recv;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state        <= S_IDLE;
      r_mode         <= '0;
      r_snap_data    <= '0;
      r_snap_width   <= '0;
      r_snap_noise   <= '0;
      r_recv         <= '0;
      r_syn          <= '0;
      r_par          <= 1'b0;
      data_out       <= '0;
      num_of_errors  <= '0;
      operation_done <= 1'b0;
    end else begin
      operation_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mode       <= PWDATA[1:0];
            r_snap_data  <= r_data_in[31:0];
            r_snap_width <= r_cw_width;
            r_snap_noise <= r_noise[31:0];
            r_state      <= S_STAGE1;
          end
        end
        S_STAGE1: begin
          r_recv  <= w_recv;
          r_syn   <= w_syn;
          r_par   <= ^w_recv;
          r_state <= S_STAGE2;
        end
        S_STAGE2: begin
          data_out       <= DATA_WIDTH'(w_result);
          num_of_errors  <= w_err;
          operation_done <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl     <= '0;
      r_data_in  <= '0;
      r_cw_width <= '0;
      r_noise    <= '0;
      r_dropped  <= 1'b0;
    end else begin
      if (w_start) r_ctrl <= PWDATA[1:0];
      if (w_wr && w_addr == c_addr_data)  r_data_in  <= PWDATA;
      if (w_wr && w_addr == c_addr_width) r_cw_width <= PWDATA[1:0];
      if (w_wr && w_addr == c_addr_noise) r_noise    <= PWDATA;
      // A drop in the same cycle as a STATUS read keeps the bit set.
      if (w_ctrl_wr && w_busy) r_dropped <= 1'b1;
      else if (w_rd_status)    r_dropped <= 1'b0;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (w_addr)
        c_addr_ctrl:   PRDATA = AMBA_WORD'(r_ctrl);
        c_addr_data:   PRDATA = r_data_in;
        c_addr_width:  PRDATA = AMBA_WORD'(r_cw_width);
        c_addr_noise:  PRDATA = r_noise;
        c_addr_status: PRDATA = AMBA_WORD'({r_dropped, num_of_errors, w_busy});
        default:       PRDATA = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
